// File: rtl/ahbl_spi_pkg.sv
// Shared types and constants for the AHB-Lite to SPI flash read bridge.
package ahbl_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [7:0] READ_CMD_DEF = 8'h03;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DATA_BITS  = 32;
    localparam int TOTAL_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;

    // Flash bytes arrive in address order; the first one lands in the low byte.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI shifter: one 64-bit frame (cmd, addr, 32 dummy out / 32 data in).
module spi_shift_engine
    import ahbl_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [7:0]  cmd_i,
    input  logic [23:0] addr_i,
    input  logic        sdi_i,
    output logic        busy_o,
    output logic        sclk_o,
    output logic        sdo_o,
    output logic        bit_end_o,
    output logic        done_o,
    output logic [5:0]  bit_idx_o,
    output logic [31:0] rx_o
);

    logic [63:0] sout_q, sout_d;
    logic [31:0] sin_q, sin_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic        busy_q, busy_d;
    logic        sclk_q, sclk_d;
    logic        half_end, rise, fall;

    assign half_end = busy_q && (div_q == 8'(CLK_DIV - 1));
    assign rise     = half_end && !sclk_q;
    assign fall     = half_end && sclk_q;

    always_comb begin
        sout_d = sout_q;
        sin_d  = sin_q;
        div_d  = div_q;
        bit_d  = bit_q;
        busy_d = busy_q;
        sclk_d = sclk_q;
        if (start_i) begin
            sout_d = {cmd_i, addr_i, 32'h0};
            busy_d = 1'b1;
            div_d  = 8'd0;
            sclk_d = 1'b0;
            bit_d  = 6'd0;
        end else if (busy_q) begin
            div_d = half_end ? 8'd0 : div_q + 8'd1;
            // MISO is captured on the same HCLK edge that raises SCLK.
            if (rise) begin
                sclk_d = 1'b1;
                sin_d  = {sin_q[30:0], sdi_i};
            end
            if (fall) begin
                sclk_d = 1'b0;
                sout_d = {sout_q[62:0], 1'b0};
                bit_d  = bit_q + 6'd1;
                if (bit_q == 6'(TOTAL_BITS - 1))
                    busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sout_q <= '0;
            sin_q  <= '0;
            div_q  <= '0;
            bit_q  <= '0;
            busy_q <= 1'b0;
            sclk_q <= 1'b0;
        end else begin
            sout_q <= sout_d;
            sin_q  <= sin_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            busy_q <= busy_d;
            sclk_q <= sclk_d;
        end
    end

    assign busy_o    = busy_q;
    assign sclk_o    = sclk_q;
    assign sdo_o     = sout_q[63];
    assign bit_end_o = fall;
    assign done_o    = fall && (bit_q == 6'(TOTAL_BITS - 1));
    assign bit_idx_o = bit_q;
    assign rx_o      = sin_q;

endmodule

// File: rtl/ahbl_spi_flash_rd.sv
// AHB-Lite read-only slave: each word read becomes one SPI flash READ frame.
module ahbl_spi_flash_rd
    import ahbl_spi_pkg::*;
#(
    parameter int         CLK_DIV  = 2,
    parameter logic [7:0] READ_CMD = READ_CMD_DEF
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        SPISCLKO,
    output logic        SPISS,
    output logic        SPISDO,
    input  logic        SPISDI
);

    state_e      state_q, state_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic        data_ready, accept, rd_start;
    logic        busy, bit_end, done;
    logic [5:0]  bit_idx;
    logic [31:0] rx;
    logic        unused_bits;

    assign unused_bits = ^{HSIZE, HWDATA, HADDR[31:24], HADDR[1:0]};

    assign data_ready = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
    assign accept     = data_ready && HSEL && HREADY &&
                        ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign rd_start   = accept && !HWRITE;

    always_comb begin
        state_d  = state_q;
        hrdata_d = hrdata_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (accept) state_d = HWRITE ? ST_ERR1 : ST_CMD;
                else        state_d = ST_IDLE;
            end
            ST_CMD:
                if (bit_end && bit_idx == 6'(CMD_BITS - 1)) state_d = ST_ADDR;
            ST_ADDR:
                if (bit_end && bit_idx == 6'(CMD_BITS + ADDR_BITS - 1)) state_d = ST_DATA;
            ST_DATA:
                if (done) begin
                    state_d  = ST_DONE;
                    hrdata_d = bswap32(rx);
                end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q  <= ST_IDLE;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            hrdata_q <= hrdata_d;
        end
    end

    spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_eng (
        .clk_i     (HCLK),
        .rst_ni    (HRESETN),
        .start_i   (rd_start),
        .cmd_i     (READ_CMD),
        .addr_i    ({HADDR[23:2], 2'b00}),
        .sdi_i     (SPISDI),
        .busy_o    (busy),
        .sclk_o    (SPISCLKO),
        .sdo_o     (SPISDO),
        .bit_end_o (bit_end),
        .done_o    (done),
        .bit_idx_o (bit_idx),
        .rx_o      (rx)
    );

    assign HREADYOUT = data_ready;
    assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign HRDATA    = hrdata_q;
    assign SPISS     = !busy;

endmodule

// File: tb/tb_ahbl_spi_flash_rd.sv
// Directed bench for ahbl_spi_flash_rd with a behavioural mode-0 READ flash model.
module tb_ahbl_spi_flash_rd;

    logic        HCLK = 1'b0;
    logic        HRESETN = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = '0;
    logic        HREADY;
    logic        HREADYOUT, HRESP;
    logic [31:0] HRDATA;
    logic        SPISCLKO, SPISS, SPISDO, SPISDI;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] flash_word = '0;
    logic [63:0] mosi = '0;
    int          rx_cnt = 0;
    int          sclk_rises = 0;

    assign HREADY = HREADYOUT;

    ahbl_spi_flash_rd #(.CLK_DIV(2), .READ_CMD(8'h03)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .SPISCLKO(SPISCLKO), .SPISS(SPISS), .SPISDO(SPISDO), .SPISDI(SPISDI)
    );

    always #5 HCLK = ~HCLK;

    // Flash: frame restarts on SS falling; bits 32..63 of the frame carry the data word.
    always @(negedge SPISS or posedge SPISCLKO) begin
        if (SPISCLKO) begin
            mosi = {mosi[62:0], SPISDO};
            rx_cnt++;
            sclk_rises++;
        end else begin
            rx_cnt = 0;
            mosi = '0;
        end
    end

    assign SPISDI = (rx_cnt >= 32 && rx_cnt < 64) ? flash_word[63 - rx_cnt] : 1'b0;

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
    endtask

    // Drive one address phase; after it is accepted either go idle or present the next one.
    task automatic addr_phase(input logic [31:0] a, input logic w,
                              input logic pipe, input logic [31:0] na);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w;
        @(posedge HCLK); #1;
        if (pipe) begin
            HADDR = na; HWRITE = 1'b0;
        end else begin
            bus_idle();
        end
    endtask

    task automatic wait_done(output logic [31:0] d, output int waits, output int ss_hi,
                             output logic [3:0] pat, output logic to);
        waits = 0; ss_hi = 0; pat = '0; to = 1'b1; d = '0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge HCLK);
            if (HREADYOUT) begin
                d = HRDATA; to = 1'b0;
                break;
            end
            if (waits < 4) pat[waits] = SPISCLKO;
            waits++;
            if (SPISS) ss_hi++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        n_cmp++;
        if (SPISS !== 1'b1 || HREADYOUT !== 1'b1) begin
            n_err++; $display("FAIL reset_hold: SS=%b HREADYOUT=%b, want 1/1", SPISS, HREADYOUT);
        end
        @(posedge HCLK); #1 HRESETN = 1'b1;
        @(negedge HCLK);
        n_cmp++;
        if ({HREADYOUT, HRESP, SPISS, SPISCLKO, SPISDO} !== 5'b10100) begin
            n_err++; $display("FAIL reset_ctl: {rdy,resp,ss,sclk,sdo}=%b want 10100",
                              {HREADYOUT, HRESP, SPISS, SPISCLKO, SPISDO});
        end
        n_cmp++;
        if (HRDATA !== 32'h0) begin
            n_err++; $display("FAIL reset_hrdata: got %h want 00000000", HRDATA);
        end
    endtask

    task automatic test_read(input logic [31:0] a, input logic [31:0] fw,
                             input logic [31:0] exp_d, input logic [31:0] exp_mosi);
        logic [31:0] d; int w, ssh; logic [3:0] pat; logic to;
        flash_word = fw;
        addr_phase(a, 1'b0, 1'b0, '0);
        wait_done(d, w, ssh, pat, to);
        n_cmp++;
        if (to !== 1'b0 || w != 256) begin
            n_err++; $display("FAIL read_waits @%h: waits=%0d timeout=%b want 256/0", a, w, to);
        end
        n_cmp++;
        if (d !== exp_d) begin
            n_err++; $display("FAIL read_data @%h: got %h want %h", a, d, exp_d);
        end
        n_cmp++;
        if (ssh != 0 || pat !== 4'b1100) begin
            n_err++; $display("FAIL read_spi @%h: ss_high=%0d sclk_pat=%b want 0/1100", a, ssh, pat);
        end
        n_cmp++;
        if ({HRESP, SPISS, SPISCLKO} !== 3'b010) begin
            n_err++; $display("FAIL read_done_ctl @%h: {resp,ss,sclk}=%b want 010", a, {HRESP, SPISS, SPISCLKO});
        end
        n_cmp++;
        if (mosi[63:32] !== exp_mosi || rx_cnt != 64) begin
            n_err++; $display("FAIL read_mosi @%h: got %h bits=%0d want %h/64", a, mosi[63:32], rx_cnt, exp_mosi);
        end
        @(negedge HCLK);
        n_cmp++;
        if (HRDATA !== exp_d || HREADYOUT !== 1'b1) begin
            n_err++; $display("FAIL read_hold @%h: HRDATA=%h rdy=%b want %h/1", a, HRDATA, HREADYOUT, exp_d);
        end
    endtask

    task automatic test_write();
        int r0;
        r0 = sclk_rises;
        addr_phase(32'h0000_0020, 1'b1, 1'b0, '0);
        @(negedge HCLK);
        n_cmp++;
        if ({HREADYOUT, HRESP, SPISS} !== 3'b011) begin
            n_err++; $display("FAIL write_err1: {rdy,resp,ss}=%b want 011", {HREADYOUT, HRESP, SPISS});
        end
        @(negedge HCLK);
        n_cmp++;
        if ({HREADYOUT, HRESP, SPISS} !== 3'b111) begin
            n_err++; $display("FAIL write_err2: {rdy,resp,ss}=%b want 111", {HREADYOUT, HRESP, SPISS});
        end
        @(negedge HCLK);
        n_cmp++;
        if ({HREADYOUT, HRESP} !== 2'b10 || sclk_rises != r0 || SPISCLKO !== 1'b0) begin
            n_err++; $display("FAIL write_after: {rdy,resp}=%b sclk_edges=%0d want 10/0",
                              {HREADYOUT, HRESP}, sclk_rises - r0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d0, d1; int w0, w1, s0, s1; logic [3:0] p0, p1; logic t0, t1;
        logic ss_done;
        flash_word = 32'h0102_0304;
        addr_phase(32'h0000_0000, 1'b0, 1'b1, 32'h0000_0004);
        wait_done(d0, w0, s0, p0, t0);
        ss_done = SPISS;
        @(posedge HCLK); #1;
        flash_word = 32'hA1B2_C3D4;
        bus_idle();
        wait_done(d1, w1, s1, p1, t1);
        n_cmp++;
        if (d0 !== 32'h0403_0201 || t0 !== 1'b0 || w0 != 256) begin
            n_err++; $display("FAIL b2b_first: got %h waits=%0d want 04030201/256", d0, w0);
        end
        n_cmp++;
        if (d1 !== 32'hD4C3_B2A1 || t1 !== 1'b0 || w1 != 256) begin
            n_err++; $display("FAIL b2b_second: got %h waits=%0d want d4c3b2a1/256", d1, w1);
        end
        n_cmp++;
        if (ss_done !== 1'b1 || s1 != 0 || mosi[63:32] !== 32'h0300_0004) begin
            n_err++; $display("FAIL b2b_ss: ss_in_done=%b ss_high_in_second=%0d mosi=%h want 1/0/03000004",
                              ss_done, s1, mosi[63:32]);
        end
    endtask

    task automatic test_idle_xfer();
        int r0, bad;
        r0 = sclk_rises; bad = 0;
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h0000_0040;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) HTRANS = 2'b01;
            @(negedge HCLK);
            if ({HREADYOUT, HRESP, SPISS} !== 3'b101) bad++;
        end
        @(posedge HCLK); #1 bus_idle();
        n_cmp++;
        if (bad != 0 || sclk_rises != r0) begin
            n_err++; $display("FAIL idle_xfer: bad_cycles=%0d sclk_edges=%0d want 0/0", bad, sclk_rises - r0);
        end
    endtask

    task automatic test_reset_mid();
        flash_word = 32'hCAFE_F00D;
        addr_phase(32'h0000_0008, 1'b0, 1'b0, '0);
        repeat (99) @(posedge HCLK);
        #3;
        n_cmp++;
        if (SPISS !== 1'b0 || HREADYOUT !== 1'b0) begin
            n_err++; $display("FAIL mid_active: ss=%b rdy=%b want 0/0", SPISS, HREADYOUT);
        end
        HRESETN = 1'b0;
        #1;
        n_cmp++;
        if ({SPISS, SPISCLKO, SPISDO, HREADYOUT, HRESP} !== 5'b10010 || HRDATA !== 32'h0) begin
            n_err++; $display("FAIL mid_reset: {ss,sclk,sdo,rdy,resp}=%b HRDATA=%h want 10010/0",
                              {SPISS, SPISCLKO, SPISDO, HREADYOUT, HRESP}, HRDATA);
        end
        @(posedge HCLK); #1 HRESETN = 1'b1;
        test_read(32'h0000_0010, 32'h5A3C_9612, 32'h1296_3C5A, 32'h0300_0010);
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_read(32'h0000_1004, 32'h1122_3344, 32'h4433_2211, 32'h0300_1004);
        test_read(32'hFFAB_CDEE, 32'hDEAD_BEEF, 32'hEFBE_ADDE, 32'h03AB_CDEC);
        test_write();
        test_back_to_back();
        test_idle_xfer();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
